// File: rtl/leaf_stream_packetizer.sv
// rtl/leaf_stream_packetizer.sv - user-to-BFT egress packetizer with credit flow control; optional retransmit via LEAF_PKT_RESEND_EN
module leaf_stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk_user,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     bft_ready,
  input  logic                     resend,
  output logic [NUM_ADDR_BITS:0]   credits
);

  localparam int CW = NUM_ADDR_BITS + 1;
  localparam logic [CW:0] CRED_MAX = (CW+1)'(2 ** NUM_ADDR_BITS);
  localparam logic [CW:0] CRED_INC = (CW+1)'(FREESPACE_UPDATE_SIZE);
  localparam int PORT_LSB = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS;

  localparam logic [1:0] ST_UNCFG = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            credits_q, credits_d;
  logic [NUM_ADDR_BITS-1:0] slot_q, slot_d;
  logic [NUM_LEAF_BITS-1:0] dst_leaf_q, dst_leaf_d;
  logic [NUM_PORT_BITS-1:0] dst_port_q, dst_port_d;
  logic [PACKET_BITS-1:0]   out_q, out_d;

  logic                     in_vld, is_cfg, is_credit;
  logic [NUM_PORT_BITS-1:0] in_port;
  logic                     out_free, accept, ack, resend_req, resend_svc;
  logic [PACKET_BITS-1:0]   pkt_new;
  logic [CW:0]              cred_sum;
  logic                     unused_ok;

  // Only a few inbound fields are decoded; the rest of the word is don't-care.
  assign unused_ok = ^{resend, din_leaf_bft2interface};

  assign in_vld    = din_leaf_bft2interface[PACKET_BITS-1];
  assign in_port   = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign is_cfg    = in_vld && (in_port == NUM_PORT_BITS'(0));
  assign is_credit = in_vld && (in_port == NUM_PORT_BITS'(1));

  // Output register can take a new word if empty or being drained this cycle.
  assign out_free = !out_q[PACKET_BITS-1] || bft_ready;
  assign pkt_new  = {1'b1, dst_leaf_q, dst_port_q, slot_q, din_leaf_user2interface};

`ifdef LEAF_PKT_RESEND_EN
  logic [PACKET_BITS-1:0] shadow_q, shadow_d;
  logic                   rpend_q, rpend_d;

  // A retransmit request blocks new words until the shadow copy is re-presented.
  assign resend_req = resend || rpend_q;
  assign resend_svc = resend_req && out_free;
  assign shadow_d   = accept ? pkt_new : shadow_q;
  assign rpend_d    = resend_req && !resend_svc;

  // Shadow of the last emitted packet plus the pending-retransmit flag.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      shadow_q <= '0;
      rpend_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      rpend_q  <= rpend_d;
    end
  end
`else
  assign resend_req = 1'b0;
  assign resend_svc = 1'b0;
`endif

  assign ack    = (state_q == ST_RUN) && (credits_q != '0) && out_free && !resend_req;
  assign accept = vld_user2interface && ack;

  assign ack_interface2user      = ack;
  assign dout_leaf_interface2bft = out_q;
  assign credits                 = credits_q;

  // Next-state logic: credit accounting, slot counter, destination and output register.
  always_comb begin
    cred_sum   = {1'b0, credits_q} + (is_credit ? CRED_INC : '0) - {{CW{1'b0}}, accept};
    credits_d  = (cred_sum > CRED_MAX) ? CRED_MAX[CW-1:0] : cred_sum[CW-1:0];
    slot_d     = accept ? slot_q + 1'b1 : slot_q;
    dst_leaf_d = is_cfg ? din_leaf_bft2interface[NUM_LEAF_BITS-1:0] : dst_leaf_q;
    dst_port_d = is_cfg ? din_leaf_bft2interface[NUM_LEAF_BITS +: NUM_PORT_BITS] : dst_port_q;

    out_d = out_q;
    if (accept) begin
      out_d = pkt_new;
    end else if (resend_svc) begin
`ifdef LEAF_PKT_RESEND_EN
      out_d = shadow_q;
`endif
    end else if (bft_ready) begin
      out_d = '0;
    end

    state_d = state_q;
    case (state_q)
      ST_UNCFG: if (is_cfg) state_d = ST_RUN;
      ST_RUN:   if (credits_d == '0) state_d = ST_STALL;
      ST_STALL: if (credits_d != '0) state_d = ST_RUN;
      default:  state_d = ST_UNCFG;
    endcase
  end

  // Main state registers; reset returns to unconfigured with a full credit pool.
  always_ff @(posedge clk_user) begin
    if (reset) begin
      state_q    <= ST_UNCFG;
      credits_q  <= CRED_MAX[CW-1:0];
      slot_q     <= '0;
      dst_leaf_q <= '0;
      dst_port_q <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      slot_q     <= slot_d;
      dst_leaf_q <= dst_leaf_d;
      dst_port_q <= dst_port_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// tb/tb_leaf_stream_packetizer.sv - self-checking bench for leaf_stream_packetizer
module tb_leaf_stream_packetizer;

  logic        clk_user = 1'b0;
  logic        reset;
  logic [31:0] din_leaf_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user;
  logic [48:0] din_leaf_bft2interface;
  logic [48:0] dout_leaf_interface2bft;
  logic        bft_ready;
  logic        resend;
  logic [7:0]  credits;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_cfgd;
  int          m_cred;
  int          m_slot;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  logic [48:0] m_out;
  logic [48:0] m_shadow;
  bit          m_rpend;

  always #5 clk_user = ~clk_user;

  leaf_stream_packetizer dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_interface2user),
    .din_leaf_bft2interface  (din_leaf_bft2interface),
    .dout_leaf_interface2bft (dout_leaf_interface2bft),
    .bft_ready               (bft_ready),
    .resend                  (resend),
    .credits                 (credits)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cfgd = 0; m_cred = 128; m_slot = 0; m_leaf = '0; m_port = '0;
    m_out = '0; m_shadow = '0; m_rpend = 0;
  endtask

  function automatic bit model_ack();
    bit a;
    a = m_cfgd && (m_cred > 0) && (!m_out[48] || bft_ready);
`ifdef LEAF_PKT_RESEND_EN
    a = a && !(resend || m_rpend);
`endif
    return a;
  endfunction

  task automatic model_update(input bit a);
    bit          acc, req, isc, iscr;
    logic [48:0] pkt;
    int          c;
    if (reset) begin
      model_reset();
      return;
    end
    acc  = vld_user2interface && a;
    isc  = din_leaf_bft2interface[48] && (din_leaf_bft2interface[42:39] == 4'd0);
    iscr = din_leaf_bft2interface[48] && (din_leaf_bft2interface[42:39] == 4'd1);
    req  = 0;
`ifdef LEAF_PKT_RESEND_EN
    req = resend || m_rpend;
`endif
    pkt = {1'b1, m_leaf, m_port, m_slot[6:0], din_leaf_user2interface};
    if (acc) begin
      m_out = pkt; m_shadow = pkt; m_slot = (m_slot + 1) % 128;
    end else if (req && (!m_out[48] || bft_ready)) begin
      m_out = m_shadow; req = 0;
    end else if (bft_ready) begin
      m_out = '0;
    end
    m_rpend = req;
    c = m_cred + (iscr ? 64 : 0) - (acc ? 1 : 0);
    m_cred = (c > 128) ? 128 : c;
    if (isc) begin
      m_cfgd = 1;
      m_leaf = din_leaf_bft2interface[4:0];
      m_port = din_leaf_bft2interface[8:5];
    end
  endtask

  // One clock: check ack before the edge, advance model, check registered outputs after.
  task automatic tick();
    bit ea;
    #1;
    ea = model_ack();
    chk("ack", ack_interface2user, ea);
    @(posedge clk_user);
    model_update(ea);
    #1;
    chk("dout", dout_leaf_interface2bft, m_out);
    chk("credits", credits, m_cred);
    @(negedge clk_user);
  endtask

  task automatic idle();
    vld_user2interface = 0; bft_ready = 1; resend = 0; din_leaf_bft2interface = '0;
  endtask

  task automatic send_cfg(input logic [4:0] leaf, input logic [3:0] port);
    idle();
    din_leaf_bft2interface = {1'b1, 5'd0, 4'd0, 7'd0, 23'd0, port, leaf};
    tick();
    din_leaf_bft2interface = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      vld_user2interface = 1; bft_ready = 1; din_leaf_user2interface = $urandom;
      tick();
    end
  endtask

  logic [48:0] held;
  int          kind;

  initial begin
    reset = 1; din_leaf_user2interface = '0;
    idle();
    model_reset();
    @(posedge clk_user); @(posedge clk_user);
    @(negedge clk_user);
    #1;
    chk("rst_ack", ack_interface2user, 0);
    chk("rst_dout", dout_leaf_interface2bft, 0);
    chk("rst_credits", credits, 128);
    reset = 0;

    // Test 1: configure and send one word
    send_cfg(5'd3, 4'd2);
    vld_user2interface = 1; din_leaf_user2interface = 32'hDEADBEEF;
    tick();
    chk("t1_dout", dout_leaf_interface2bft, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});
    chk("t1_credits", credits, 127);

    // Test 2: exhaust the credit pool, then one CREDIT
    stream(127);
    chk("t2_credits0", credits, 0);
    vld_user2interface = 1;
    #1;
    chk("t2_ack_stall", ack_interface2user, 0);
    tick();
    idle();
    din_leaf_bft2interface = {1'b1, 5'd0, 4'd1, 39'd0};
    tick();
    idle();
    vld_user2interface = 1; din_leaf_user2interface = $urandom;
    #1;
    chk("t2_ack_after_credit", ack_interface2user, 1);
    tick();
    chk("t2_slot_wrap", dout_leaf_interface2bft[38:32], 0);

    // Test 3: back-pressure holds the output stable
    stream(3);
    bft_ready = 0;
    held = m_out;
    for (int i = 0; i < 5; i++) begin
      vld_user2interface = 1; din_leaf_user2interface = $urandom;
      #1;
      chk("t3_ack_hold", ack_interface2user, 0);
      tick();
      chk("t3_dout_hold", dout_leaf_interface2bft, held);
    end
    stream(4);

    // Test 4: CREDIT and accept together at credits==10
    do_reset();
    send_cfg(5'd7, 4'd9);
    stream(118);
    chk("t4_credits10", credits, 10);
    vld_user2interface = 1; bft_ready = 1; din_leaf_user2interface = $urandom;
    din_leaf_bft2interface = {1'b1, 5'd0, 4'd1, 39'd0};
    tick();
    chk("t4_credits73", credits, 73);
    idle();

    // Test 5: reset with a packet pending
    vld_user2interface = 1; bft_ready = 0; din_leaf_user2interface = $urandom;
    tick();
    chk("t5_pending", dout_leaf_interface2bft[48], 1);
    do_reset();
    chk("t5_dout", dout_leaf_interface2bft, 0);
    chk("t5_credits", credits, 128);
    for (int i = 0; i < 3; i++) begin
      vld_user2interface = 1; din_leaf_user2interface = $urandom;
      #1;
      chk("t5_ack_uncfg", ack_interface2user, 0);
      tick();
    end

    // Test 6: resend after slot 5 drains
    send_cfg(5'd4, 4'd1);
    for (int i = 0; i < 6; i++) begin
      vld_user2interface = 1; bft_ready = 1; din_leaf_user2interface = 32'h1000 + i;
      tick();
    end
    chk("t6_slot5", dout_leaf_interface2bft, {1'b1, 5'd4, 4'd1, 7'd5, 32'h1005});
    idle();
    tick();
    chk("t6_drained", dout_leaf_interface2bft[48], 0);
    resend = 1;
    tick();
    resend = 0;
`ifdef LEAF_PKT_RESEND_EN
    chk("t6_resend_pkt", dout_leaf_interface2bft, {1'b1, 5'd4, 4'd1, 7'd5, 32'h1005});
`else
    chk("t6_no_resend", dout_leaf_interface2bft[48], 0);
`endif
    chk("t6_credits", credits, 122);
    tick();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      vld_user2interface = ($urandom_range(0, 3) != 0);
      din_leaf_user2interface = $urandom;
      bft_ready = ($urandom_range(0, 9) < 7);
      resend = ($urandom_range(0, 39) == 0);
      kind = $urandom_range(0, 11);
      case (kind)
        0: din_leaf_bft2interface = {1'b1, 5'($urandom), 4'd0, 7'($urandom), 23'($urandom), 4'($urandom), 5'($urandom)};
        1: din_leaf_bft2interface = {1'b1, 5'($urandom), 4'd1, 39'($urandom)};
        2: din_leaf_bft2interface = {1'b1, 5'($urandom), 4'd7, 39'($urandom)};
        3: din_leaf_bft2interface = {1'b0, 5'd0, 4'd1, 39'($urandom)};
        default: din_leaf_bft2interface = '0;
      endcase
      tick();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
